// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared AES datapath types and helpers.
//   byte_t  : one state byte
//   word_t  : one 32-bit state column, {row0,row1,row2,row3}, row0 in 31:24
//   state_t : full 128-bit state, column-major, column 0 in bits 127:96
//   NB      : number of columns (and rows) in the state
//   MODE_INV / MODE_FWD : permutation direction selectors
//   getByte : extracts byte (row, col) from a state_t
// -----------------------------------------------------------------------------
package aes_pkg;

   typedef logic [7:0]   byte_t;
   typedef logic [31:0]  word_t;
   typedef logic [127:0] state_t;

   localparam int NB       = 4;
   localparam bit MODE_INV = 1'b1;
   localparam bit MODE_FWD = 1'b0;

   // Byte (row, col) lives at linear position 4*col+row counted from the MSB end.
   function automatic byte_t getByte(state_t s, logic [1:0] row, logic [1:0] col);
      logic [3:0] pos;
      pos = {col, row};
      return s[8*(15 - int'(pos)) +: 8];
   endfunction

endpackage

// File: rtl/inv_shift_rows_stream_if.sv
// -----------------------------------------------------------------------------
// inv_shift_rows_stream_if
// Column-serial stream bundle for the ShiftRows permuter.
//   S_in / S_valid_in / S_ready_out       : input column handshake
//   D_out / D_valid_out / D_ready_in      : output column handshake
//   D_idx_out                             : column index (0..3) of D_out
//   D_last_out                            : high with column 3 of a block
// Modports:
//   slave  : the permuter itself
//   master : the environment (producer + consumer) around it
// -----------------------------------------------------------------------------
interface inv_shift_rows_stream_if;
   import aes_pkg::*;

   word_t       S_in;
   logic        S_valid_in;
   logic        S_ready_out;
   word_t       D_out;
   logic        D_valid_out;
   logic        D_ready_in;
   logic [1:0]  D_idx_out;
   logic        D_last_out;

   modport slave (
      input  S_in, S_valid_in, D_ready_in,
      output S_ready_out, D_out, D_valid_out, D_idx_out, D_last_out
   );

   modport master (
      output S_in, S_valid_in, D_ready_in,
      input  S_ready_out, D_out, D_valid_out, D_idx_out, D_last_out
   );

endinterface

// File: rtl/inv_shift_rows_stream_perm.sv
// -----------------------------------------------------------------------------
// shift_rows_perm
// Purely combinational 128->128 AES row rotation.
//   MODE = MODE_INV : out[r][c] = in[r][(c-r) mod 4]   (InvShiftRows)
//   MODE = MODE_FWD : out[r][c] = in[r][(c+r) mod 4]   (ShiftRows)
// Ports:
//   state_i : input state, column-major
//   state_o : permuted state, same layout
// -----------------------------------------------------------------------------
module shift_rows_perm
   import aes_pkg::*;
#(
   parameter bit MODE = MODE_INV
) (
   input  state_t state_i,
   output state_t state_o
);

   // Pure wiring: each output byte picks its source column at elaboration time.
   for (genvar c = 0; c < NB; c++) begin : g_col
      for (genvar r = 0; r < NB; r++) begin : g_row
         localparam int SRC = MODE ? ((c - r + NB) % NB) : ((c + r) % NB);
         assign state_o[8*(15 - (4*c + r)) +: 8] = getByte(state_i, 2'(r), 2'(SRC));
      end
   end

endmodule

// File: rtl/inv_shift_rows_stream.sv
// -----------------------------------------------------------------------------
// inv_shift_rows_stream
// Column-serial AES InvShiftRows (or ShiftRows) permuter with ping-pong
// buffering for a sustained rate of one column per cycle.
// Parameters:
//   MODE : MODE_INV (1) selects InvShiftRows, MODE_FWD (0) selects ShiftRows
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset, drops partial blocks
//   io  : stream bundle (slave modport), input and output column handshakes
// -----------------------------------------------------------------------------
module inv_shift_rows_stream
   import aes_pkg::*;
#(
   parameter bit MODE = MODE_INV
) (
   input  logic                    clk,
   input  logic                    rst,
   inv_shift_rows_stream_if.slave  io
);

   state_t      bank_q [2];
   logic [1:0]  full_q, full_d;
   logic        wrBank_q, wrBank_d;
   logic        rdBank_q, rdBank_d;
   logic [1:0]  wrCnt_q, wrCnt_d;
   logic [1:0]  rdCnt_q, rdCnt_d;

   logic        sReady;
   logic        dValid;
   logic        sAccept;
   logic        dAccept;
   state_t      permState;
   word_t       permCol;

   // Both handshake flags come straight from registered full flags, so a bank
   // freed this cycle only becomes writable on the next one.
   assign sReady  = !full_q[wrBank_q];
   assign dValid  = full_q[rdBank_q];
   assign sAccept = io.S_valid_in && sReady;
   assign dAccept = dValid && io.D_ready_in;

   // Next-state for pointers, counters and flags. A write only targets an empty
   // bank and a read only a full one, so both sides never touch the same flag.
   always_comb begin
      full_d   = full_q;
      wrBank_d = wrBank_q;
      rdBank_d = rdBank_q;
      wrCnt_d  = wrCnt_q;
      rdCnt_d  = rdCnt_q;
      if (sAccept) begin
         wrCnt_d = wrCnt_q + 2'd1;
         if (wrCnt_q == 2'd3) begin
            full_d[wrBank_q] = 1'b1;
            wrBank_d         = ~wrBank_q;
         end
      end
      if (dAccept) begin
         rdCnt_d = rdCnt_q + 2'd1;
         if (rdCnt_q == 2'd3) begin
            full_d[rdBank_q] = 1'b0;
            rdBank_d         = ~rdBank_q;
         end
      end
   end

   // Control state register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         full_q   <= 2'b00;
         wrBank_q <= 1'b0;
         rdBank_q <= 1'b0;
         wrCnt_q  <= 2'd0;
         rdCnt_q  <= 2'd0;
      end else begin
         full_q   <= full_d;
         wrBank_q <= wrBank_d;
         rdBank_q <= rdBank_d;
         wrCnt_q  <= wrCnt_d;
         rdCnt_q  <= rdCnt_d;
      end
   end

   // Bank storage needs no reset: contents are only observed behind a full flag.
   // Column k sits at bit offset 32*(3-k), which is {~k, 5'b0}.
   always_ff @(posedge clk) begin
      if (sAccept) begin
         bank_q[wrBank_q][{~wrCnt_q, 5'b0} +: 32] <= io.S_in;
      end
   end

   shift_rows_perm #(
      .MODE (MODE)
   ) u_perm (
      .state_i (bank_q[rdBank_q]),
      .state_o (permState)
   );

   assign permCol = permState[{~rdCnt_q, 5'b0} +: 32];

   // Outputs are forced to zero whenever nothing valid is presented.
   assign io.S_ready_out = sReady;
   assign io.D_valid_out = dValid;
   assign io.D_out       = dValid ? permCol : '0;
   assign io.D_idx_out   = dValid ? rdCnt_q : 2'd0;
   assign io.D_last_out  = dValid && (rdCnt_q == 2'd3);

endmodule

// File: tb/tb_inv_shift_rows_stream.sv
// -----------------------------------------------------------------------------
// tb_inv_shift_rows_stream
// Self-checking bench for inv_shift_rows_stream. An inverse and a forward
// instance share one stimulus stream and are scored against a byte-level
// reference permutation; a forward->inverse chain checks round-trip identity.
// -----------------------------------------------------------------------------
module tb_inv_shift_rows_stream;
   import aes_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   inv_shift_rows_stream_if ifInv ();
   inv_shift_rows_stream_if ifFwd ();
   inv_shift_rows_stream_if ifCf ();
   inv_shift_rows_stream_if ifCi ();

   word_t sIn;
   logic  sValid;
   logic  dReady;
   word_t cIn;
   logic  cValid;
   logic  cReady;

   assign ifInv.S_in       = sIn;
   assign ifInv.S_valid_in = sValid;
   assign ifInv.D_ready_in = dReady;
   assign ifFwd.S_in       = sIn;
   assign ifFwd.S_valid_in = sValid;
   assign ifFwd.D_ready_in = dReady;

   assign ifCf.S_in       = cIn;
   assign ifCf.S_valid_in = cValid;
   assign ifCf.D_ready_in = ifCi.S_ready_out;
   assign ifCi.S_in       = ifCf.D_out;
   assign ifCi.S_valid_in = ifCf.D_valid_out;
   assign ifCi.D_ready_in = cReady;

   inv_shift_rows_stream #(.MODE(MODE_INV)) dutInv   (.clk(clk), .rst(rst), .io(ifInv));
   inv_shift_rows_stream #(.MODE(MODE_FWD)) dutFwd   (.clk(clk), .rst(rst), .io(ifFwd));
   inv_shift_rows_stream #(.MODE(MODE_FWD)) chainFwd (.clk(clk), .rst(rst), .io(ifCf));
   inv_shift_rows_stream #(.MODE(MODE_INV)) chainInv (.clk(clk), .rst(rst), .io(ifCi));

   int checks = 0;
   int errors = 0;

   // Expected output beats are {idx[1:0], column[31:0]}.
   logic [33:0]  expInv [$];
   logic [33:0]  expFwd [$];
   word_t        pendQ  [$];
   logic [127:0] inBuf;
   int           inCnt;
   bit           holdValid;

   word_t kvA [4];
   word_t kvB [4];

   // Reference: walk the state as a 4x4 byte grid and rotate each row.
   function automatic logic [127:0] refPerm(logic [127:0] blk, bit inv);
      logic [127:0] res;
      int src;
      res = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            src = inv ? (c - r + 4) % 4 : (c + r) % 4;
            res[127 - 32*c - 8*r -: 8] = blk[127 - 32*src - 8*r -: 8];
         end
      end
      return res;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Collects accepted columns and queues the expected permuted blocks.
   task automatic modelAccept(word_t d);
      logic [127:0] resI;
      logic [127:0] resF;
      inBuf[127 - 32*inCnt -: 32] = d;
      inCnt++;
      if (inCnt == 4) begin
         resI = refPerm(inBuf, 1'b1);
         resF = refPerm(inBuf, 1'b0);
         for (int k = 0; k < 4; k++) begin
            expInv.push_back({2'(k), resI[127 - 32*k -: 32]});
            expFwd.push_back({2'(k), resF[127 - 32*k -: 32]});
         end
         inCnt = 0;
      end
   endtask

   // Compares both shared-stimulus instances against their scoreboards.
   task automatic checkOutput();
      logic [33:0] e;
      if (ifInv.D_valid_out) begin
         if (expInv.size() == 0) chk("invSpurious", 32'(ifInv.D_valid_out), 32'd0);
         else begin
            e = expInv[0];
            chk("invData", ifInv.D_out, e[31:0]);
            chk("invIdx", 32'(ifInv.D_idx_out), 32'(e[33:32]));
            chk("invLast", 32'(ifInv.D_last_out), 32'(e[33:32] == 2'd3));
            if (dReady) void'(expInv.pop_front());
         end
      end else chk("invGate", ifInv.D_out, 32'd0);
      if (ifFwd.D_valid_out) begin
         if (expFwd.size() == 0) chk("fwdSpurious", 32'(ifFwd.D_valid_out), 32'd0);
         else begin
            e = expFwd[0];
            chk("fwdData", ifFwd.D_out, e[31:0]);
            chk("fwdIdx", 32'(ifFwd.D_idx_out), 32'(e[33:32]));
            chk("fwdLast", 32'(ifFwd.D_last_out), 32'(e[33:32] == 2'd3));
            if (dReady) void'(expFwd.pop_front());
         end
      end else chk("fwdGate", ifFwd.D_out, 32'd0);
   endtask

   // One cycle: drive inputs, score outputs, record any input transfer, advance.
   task automatic applyStimulus(input logic v, input word_t d, input logic r, output logic acc);
      sValid = v;
      sIn    = d;
      dReady = r;
      checkOutput();
      acc = v && ifInv.S_ready_out;
      if (acc) modelAccept(d);
      @(posedge clk);
      #1;
   endtask

   task automatic resetDut();
      rst    = 1'b1;
      sValid = 1'b0;
      dReady = 1'b0;
      cValid = 1'b0;
      cReady = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Pushes pendQ through with random gaps, holding a presented column until taken.
   task automatic runStream(int vPct, int rPct, int maxCycles, string tag);
      int n;
      logic v, r, acc;
      word_t d;
      n = 0;
      while ((pendQ.size() > 0 || expInv.size() > 0 || expFwd.size() > 0) && n < maxCycles) begin
         v = (pendQ.size() > 0) && (holdValid || ($urandom_range(99) < vPct));
         d = (pendQ.size() > 0) ? pendQ[0] : 32'd0;
         r = ($urandom_range(99) < rPct);
         applyStimulus(v, d, r, acc);
         if (acc) begin
            void'(pendQ.pop_front());
            holdValid = 1'b0;
         end else holdValid = v;
         n++;
      end
      holdValid = 1'b0;
      chk({tag, "Drained"}, 32'(pendQ.size() + expInv.size() + expFwd.size()), 32'd0);
   endtask

   initial begin
      logic  v, acc;
      word_t d;
      int    acceptCnt;
      int    n;
      bit    cHold;
      word_t cPend [$];
      word_t cExp  [$];

      sValid = 1'b0; sIn = '0; dReady = 1'b0;
      cValid = 1'b0; cIn = '0; cReady = 1'b0;
      inCnt = 0; holdValid = 1'b0; inBuf = '0;
      kvA = '{32'h632FAFA2, 32'hEB93C720, 32'h9F92ABCB, 32'hA0C0302B};
      kvB = '{32'h63C0AB20, 32'hEB2F30CB, 32'h9F93AF2B, 32'hA092C7A2};

      $display("[TB] reset state");
      resetDut();
      chk("rstValid", 32'(ifInv.D_valid_out), 32'd0);
      chk("rstReady", 32'(ifInv.S_ready_out), 32'd1);
      chk("rstIdx", 32'(ifInv.D_idx_out), 32'd0);
      chk("rstLast", 32'(ifInv.D_last_out), 32'd0);
      chk("rstData", ifInv.D_out, 32'd0);
      chk("rstFwdReady", 32'(ifFwd.S_ready_out), 32'd1);

      $display("[TB] known vector, inverse");
      for (int k = 0; k < 4; k++) pendQ.push_back(kvA[k]);
      for (int i = 0; i < 9; i++) begin
         if (i == 3) chk("latencyEarly", 32'(ifInv.D_valid_out), 32'd0);
         if (i == 4) chk("latencyFirst", 32'(ifInv.D_valid_out), 32'd1);
         if (i >= 4 && i <= 7) begin
            chk("kvInvData", ifInv.D_out, kvB[i-4]);
            chk("kvInvIdx", 32'(ifInv.D_idx_out), 32'(i - 4));
            chk("kvInvLast", 32'(ifInv.D_last_out), 32'(i == 7));
         end
         v = pendQ.size() > 0;
         d = v ? pendQ[0] : 32'd0;
         applyStimulus(v, d, 1'b1, acc);
         if (acc) void'(pendQ.pop_front());
      end

      $display("[TB] known vector, forward");
      for (int k = 0; k < 4; k++) pendQ.push_back(kvB[k]);
      for (int i = 0; i < 9; i++) begin
         if (i >= 4 && i <= 7) begin
            chk("kvFwdData", ifFwd.D_out, kvA[i-4]);
            chk("kvFwdIdx", 32'(ifFwd.D_idx_out), 32'(i - 4));
         end
         v = pendQ.size() > 0;
         d = v ? pendQ[0] : 32'd0;
         applyStimulus(v, d, 1'b1, acc);
         if (acc) void'(pendQ.pop_front());
      end

      $display("[TB] streaming 8 blocks");
      for (int k = 0; k < 32; k++) pendQ.push_back($urandom);
      for (int i = 0; i < 36; i++) begin
         if (i < 32) chk("streamReady", 32'(ifInv.S_ready_out), 32'd1);
         if (i >= 4) chk("streamValid", 32'(ifInv.D_valid_out), 32'd1);
         if (i == 8) chk("swapIdx", 32'(ifInv.D_idx_out), 32'd0);
         v = pendQ.size() > 0;
         d = v ? pendQ[0] : 32'd0;
         applyStimulus(v, d, 1'b1, acc);
         if (acc) void'(pendQ.pop_front());
      end
      chk("streamDrained", 32'(pendQ.size() + expInv.size() + expFwd.size()), 32'd0);

      $display("[TB] backpressure");
      acceptCnt = 0;
      for (int k = 0; k < 12; k++) pendQ.push_back($urandom);
      for (int i = 0; i < 12; i++) begin
         chk("bpReady", 32'(ifInv.S_ready_out), 32'(i < 8));
         applyStimulus(1'b1, pendQ[0], 1'b0, acc);
         if (acc) begin
            void'(pendQ.pop_front());
            acceptCnt++;
         end
      end
      chk("bpAccepts", 32'(acceptCnt), 32'd8);
      holdValid = 1'b1;
      runStream(100, 100, 200, "bp");

      $display("[TB] reset mid-block");
      for (int k = 0; k < 6; k++) pendQ.push_back($urandom);
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b1, pendQ[0], 1'b1, acc);
         if (acc) void'(pendQ.pop_front());
      end
      chk("preRstValid", 32'(ifInv.D_valid_out), 32'd1);
      chk("preRstIdx", 32'(ifInv.D_idx_out), 32'd2);
      resetDut();
      expInv.delete(); expFwd.delete(); pendQ.delete();
      inCnt = 0; holdValid = 1'b0;
      chk("postRstValid", 32'(ifInv.D_valid_out), 32'd0);
      chk("postRstReady", 32'(ifInv.S_ready_out), 32'd1);
      chk("postRstIdx", 32'(ifInv.D_idx_out), 32'd0);
      chk("postRstData", ifInv.D_out, 32'd0);
      for (int k = 0; k < 4; k++) pendQ.push_back($urandom);
      runStream(100, 100, 100, "postRst");

      $display("[TB] random traffic");
      for (int k = 0; k < 80; k++) pendQ.push_back($urandom);
      runStream(70, 60, 2000, "rand");

      $display("[TB] forward->inverse round trip");
      for (int k = 0; k < 400; k++) begin
         d = $urandom;
         cPend.push_back(d);
         cExp.push_back(d);
      end
      n = 0;
      cHold = 1'b0;
      while ((cPend.size() > 0 || cExp.size() > 0) && n < 5000) begin
         v = (cPend.size() > 0) && (cHold || ($urandom_range(99) < 80));
         cValid = v;
         cIn    = (cPend.size() > 0) ? cPend[0] : 32'd0;
         cReady = ($urandom_range(99) < 75);
         if (ifCi.D_valid_out) begin
            if (cExp.size() == 0) chk("chainSpurious", 32'(ifCi.D_valid_out), 32'd0);
            else begin
               chk("chainData", ifCi.D_out, cExp[0]);
               if (cReady) void'(cExp.pop_front());
            end
         end
         acc = v && ifCf.S_ready_out;
         if (acc) begin
            void'(cPend.pop_front());
            cHold = 1'b0;
         end else cHold = v;
         @(posedge clk);
         #1;
         n++;
      end
      cValid = 1'b0;
      chk("chainDrained", 32'(cPend.size() + cExp.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
